// File: rtl/poc_rd_checker.sv
// rtl/poc_rd_checker.sv - PoC read-data checker: compares PHY read beats against the fixed PoC write pattern.
// Two-stage pipeline (capture, per-byte compare) feeding sticky result counters.
module poc_rd_checker #(
    parameter int nCK_PER_CLK    = 4,
    parameter int DQ_WIDTH       = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int W             = 2 * nCK_PER_CLK * DQ_WIDTH,
    localparam int LANES         = W / 8,
    localparam int TW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [7:0]       num_beats,
    input  logic             phy_rddata_valid,
    input  logic [W-1:0]     phy_rd_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             overrun,
    output logic [7:0]       beat_cnt,
    output logic [7:0]       err_cnt,
    output logic             first_err_valid,
    output logic [6:0]       first_err_idx,
    output logic [LANES-1:0] err_lane_mask
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         nb_q, nb_d;
    logic [7:0]         acc_q, acc_d;
    logic [TW-1:0]      to_q, to_d;

    logic               s1_vld_q, s1_vld_d;
    logic [W-1:0]       s1_data_q, s1_data_d;
    logic [6:0]         s1_idx_q, s1_idx_d;
    logic               s2_vld_q, s2_vld_d;
    logic [LANES-1:0]   s2_mask_q, s2_mask_d;
    logic [6:0]         s2_idx_q, s2_idx_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               fev_q, fev_d;
    logic [6:0]         fei_q, fei_d;
    logic [LANES-1:0]   mask_q, mask_d;

    logic               arm_ok;
    logic               accept;

    always_comb begin
        state_d    = state_q;
        nb_d       = nb_q;
        acc_d      = acc_q;
        to_d       = to_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        fev_d      = fev_q;
        fei_d      = fei_q;
        mask_d     = mask_q;

        arm_ok = arm && (state_q != S_CHECK);
        accept = (state_q == S_CHECK) && phy_rddata_valid && (acc_q < nb_q);

        s1_vld_d  = accept;
        s1_data_d = accept ? phy_rd_data : s1_data_q;
        s1_idx_d  = acc_q[6:0];

        s2_vld_d = s1_vld_q;
        s2_idx_d = s1_idx_q;
        for (int k = 0; k < LANES; k++) begin
            s2_mask_d[k] = (s1_data_q[8*k +: 8] != 8'(63 - k));
        end

        if (accept) begin
            acc_d = acc_q + 8'd1;
        end

        // Retirement keeps running in DONE so beats in flight at timeout still count.
        if (s2_vld_q) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (|s2_mask_q) begin
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (!fev_q) begin
                    fev_d = 1'b1;
                    fei_d = s2_idx_q;
                end
            end
            mask_d = mask_q | s2_mask_q;
        end

        if (phy_rddata_valid && !arm_ok && !accept) begin
            overrun_d = 1'b1;
        end

        if (state_q == S_CHECK) begin
            to_d = accept ? '0 : to_q + TW'(1);
            if (s2_vld_q && ({1'b0, s2_idx_q} == nb_q - 8'd1)) begin
                state_d = S_DONE;
            end else if (!accept && (to_q == TW'(TIMEOUT_CYCLES - 1))) begin
                timeout_d = 1'b1;
                state_d   = S_DONE;
            end
            if (state_d == S_DONE) begin
                pass_d = (err_cnt_d == 8'd0) && !timeout_d && !overrun_d &&
                         (beat_cnt_d == nb_q);
            end
        end

        if (arm_ok) begin
            nb_d       = num_beats;
            acc_d      = '0;
            to_d       = '0;
            s1_vld_d   = 1'b0;
            s2_vld_d   = 1'b0;
            timeout_d  = 1'b0;
            overrun_d  = 1'b0;
            beat_cnt_d = '0;
            err_cnt_d  = '0;
            fev_d      = 1'b0;
            fei_d      = '0;
            mask_d     = '0;
            if (num_beats == 8'd0) begin
                state_d = S_DONE;
                pass_d  = 1'b1;
            end else begin
                state_d = S_CHECK;
                pass_d  = 1'b0;
            end
        end

        busy_d = (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nb_q       <= '0;
            acc_q      <= '0;
            to_q       <= '0;
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_idx_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_mask_q  <= '0;
            s2_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            fev_q      <= 1'b0;
            fei_q      <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            nb_q       <= nb_d;
            acc_q      <= acc_d;
            to_q       <= to_d;
            s1_vld_q   <= s1_vld_d;
            s1_data_q  <= s1_data_d;
            s1_idx_q   <= s1_idx_d;
            s2_vld_q   <= s2_vld_d;
            s2_mask_q  <= s2_mask_d;
            s2_idx_q   <= s2_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fev_q      <= fev_d;
            fei_q      <= fei_d;
            mask_q     <= mask_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign overrun         = overrun_q;
    assign beat_cnt        = beat_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;
    assign err_lane_mask   = mask_q;

endmodule

// File: tb/tb_poc_rd_checker.sv
// tb/tb_poc_rd_checker.sv - scoreboard bench for poc_rd_checker.
module tb_poc_rd_checker;

    localparam int W     = 512;
    localparam int LANES = 64;
    localparam int TO    = 4096;

    logic             clk;
    logic             rst;
    logic             arm;
    logic [7:0]       num_beats;
    logic             phy_rddata_valid;
    logic [W-1:0]     phy_rd_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             overrun;
    logic [7:0]       beat_cnt;
    logic [7:0]       err_cnt;
    logic             first_err_valid;
    logic [6:0]       first_err_idx;
    logic [LANES-1:0] err_lane_mask;

    poc_rd_checker #(
        .nCK_PER_CLK    (4),
        .DQ_WIDTH       (64),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .arm              (arm),
        .num_beats        (num_beats),
        .phy_rddata_valid (phy_rddata_valid),
        .phy_rd_data      (phy_rd_data),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout),
        .overrun          (overrun),
        .beat_cnt         (beat_cnt),
        .err_cnt          (err_cnt),
        .first_err_valid  (first_err_valid),
        .first_err_idx    (first_err_idx),
        .err_lane_mask    (err_lane_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic        ovr;
        logic [7:0]  bc;
        logic [7:0]  ec;
        logic        fev;
        logic [6:0]  fei;
        logic [63:0] mask;
    } res_t;

    res_t         sb[$];
    logic [W-1:0] bq[$];
    int           gq[$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gold();
        logic [W-1:0] g;
        for (int k = 0; k < LANES; k++) g[8*k +: 8] = 8'(63 - k);
        return g;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ":busy"}, 64'(busy), 0);
        check({tag, ":done"}, 64'(done), 0);
        check({tag, ":pass"}, 64'(pass), 0);
        check({tag, ":timeout"}, 64'(timeout), 0);
        check({tag, ":overrun"}, 64'(overrun), 0);
        check({tag, ":beat_cnt"}, 64'(beat_cnt), 0);
        check({tag, ":err_cnt"}, 64'(err_cnt), 0);
        check({tag, ":fev"}, 64'(first_err_valid), 0);
        check({tag, ":fei"}, 64'(first_err_idx), 0);
        check({tag, ":mask"}, err_lane_mask, 0);
    endtask

    task automatic do_arm(input logic [7:0] nb);
        @(posedge clk); #1;
        arm = 1'b1;
        num_beats = nb;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic drive_beats();
        for (int i = 0; i < bq.size(); i++) begin
            if (gq[i] > 0) begin
                phy_rddata_valid = 1'b0;
                repeat (gq[i]) begin @(posedge clk); #1; end
            end
            phy_rddata_valid = 1'b1;
            phy_rd_data = bq[i];
            @(posedge clk); #1;
        end
        phy_rddata_valid = 1'b0;
    endtask

    // Arm, predict the run result into the scoreboard, drive, then retire on done.
    task automatic run(input string name, input logic [7:0] nb, input int exp_lat);
        res_t         e;
        res_t         got;
        int           acc;
        int           lat;
        logic [63:0]  m;
        logic [W-1:0] g;
        e = '0;
        acc = 0;
        g = gold();
        for (int i = 0; i < bq.size(); i++) begin
            if (acc < int'(nb)) begin
                for (int k = 0; k < LANES; k++) m[k] = (bq[i][8*k +: 8] != g[8*k +: 8]);
                if (|m) begin
                    if (e.ec != 8'hFF) e.ec = e.ec + 8'd1;
                    if (!e.fev) begin
                        e.fev = 1'b1;
                        e.fei = 7'(acc);
                    end
                end
                e.mask = e.mask | m;
                acc++;
            end else begin
                e.ovr = 1'b1;
            end
        end
        e.bc   = 8'(acc);
        e.tmo  = (acc < int'(nb));
        e.pass = (e.ec == 0) && !e.tmo && !e.ovr && (e.bc == nb);
        sb.push_back(e);

        do_arm(nb);
        drive_beats();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < TO + 200);
        check({name, ":done_seen"}, 64'(done), 1);
        if (exp_lat > 0) check({name, ":latency"}, 64'(lat), 64'(exp_lat));
        got.pass = pass;
        got.tmo  = timeout;
        got.ovr  = overrun;
        got.bc   = beat_cnt;
        got.ec   = err_cnt;
        got.fev  = first_err_valid;
        got.fei  = first_err_idx;
        got.mask = err_lane_mask;
        e = sb.pop_front();
        check({name, ":pass"}, 64'(got.pass), 64'(e.pass));
        check({name, ":timeout"}, 64'(got.tmo), 64'(e.tmo));
        check({name, ":overrun"}, 64'(got.ovr), 64'(e.ovr));
        check({name, ":beat_cnt"}, 64'(got.bc), 64'(e.bc));
        check({name, ":err_cnt"}, 64'(got.ec), 64'(e.ec));
        check({name, ":fev"}, 64'(got.fev), 64'(e.fev));
        check({name, ":fei"}, 64'(got.fei), 64'(e.fei));
        check({name, ":mask"}, got.mask, e.mask);
        repeat (4) @(negedge clk);
        check({name, ":hold_done"}, 64'(done), 1);
        check({name, ":hold_beat_cnt"}, 64'(beat_cnt), 64'(e.bc));
    endtask

    initial begin
        logic [W-1:0] b;
        int           nb;
        rst = 1'b1;
        arm = 1'b0;
        num_beats = '0;
        phy_rddata_valid = 1'b0;
        phy_rd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Valid while idle flags overrun; arm with valid in the same cycle wins.
        phy_rddata_valid = 1'b1;
        phy_rd_data = gold();
        @(posedge clk); #1;
        phy_rddata_valid = 1'b0;
        @(negedge clk);
        check("idle_valid:overrun", 64'(overrun), 1);
        check("idle_valid:done", 64'(done), 0);
        @(posedge clk); #1;
        arm = 1'b1;
        num_beats = 8'd0;
        phy_rddata_valid = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        phy_rddata_valid = 1'b0;
        @(negedge clk);
        check("arm_valid:overrun", 64'(overrun), 0);
        check("arm_valid:done", 64'(done), 1);
        check("arm_valid:pass", 64'(pass), 1);

        // Full 128-beat back-to-back run.
        bq.delete(); gq.delete();
        for (int i = 0; i < 128; i++) begin bq.push_back(gold()); gq.push_back(0); end
        run("full128", 8'd128, 3);

        // Single corrupted byte on beat 2.
        bq.delete(); gq.delete();
        for (int i = 0; i < 4; i++) begin
            b = gold();
            if (i == 2) b[8*5 +: 8] = 8'hFF;
            bq.push_back(b); gq.push_back(0);
        end
        run("err_b2", 8'd4, 3);

        // Zero-beat arm right after a failing run must clear every result.
        @(posedge clk); #1;
        arm = 1'b1;
        num_beats = 8'd0;
        @(posedge clk); #1;
        arm = 1'b0;
        @(negedge clk);
        check("nb0:done", 64'(done), 1);
        check("nb0:pass", 64'(pass), 1);
        check("nb0:busy", 64'(busy), 0);
        check("nb0:err_cnt", 64'(err_cnt), 0);
        check("nb0:beat_cnt", 64'(beat_cnt), 0);
        check("nb0:fev", 64'(first_err_valid), 0);
        check("nb0:mask", err_lane_mask, 0);

        // Overrun: one extra beat past num_beats.
        bq.delete(); gq.delete();
        for (int i = 0; i < 3; i++) begin bq.push_back(gold()); gq.push_back(0); end
        run("overrun", 8'd2, 2);

        // Timeout: 3 of 8 beats, then silence.
        bq.delete(); gq.delete();
        for (int i = 0; i < 3; i++) begin bq.push_back(gold()); gq.push_back(0); end
        run("timeout", 8'd8, TO + 1);

        // Random runs with gaps and scattered corruption.
        for (int r = 0; r < 6; r++) begin
            bq.delete(); gq.delete();
            nb = int'($urandom_range(1, 20));
            for (int i = 0; i < nb; i++) begin
                b = gold();
                if ($urandom_range(0, 3) == 0) begin
                    b[8*$urandom_range(0, LANES-1) +: 8] ^= 8'($urandom_range(1, 255));
                    if ($urandom_range(0, 1) == 1)
                        b[8*$urandom_range(0, LANES-1) +: 8] ^= 8'($urandom_range(1, 255));
                end
                bq.push_back(b);
                gq.push_back(int'($urandom_range(0, 3)));
            end
            run($sformatf("rand%0d", r), 8'(nb), 0);
        end

        // Reset mid-run after 10 beats, with beats still in the pipeline.
        bq.delete(); gq.delete();
        for (int i = 0; i < 10; i++) begin
            b = gold();
            if (i == 1) b[0 +: 8] = 8'h00;
            bq.push_back(b); gq.push_back(0);
        end
        do_arm(8'd20);
        drive_beats();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        repeat (3) @(negedge clk);
        check("midrst_flush:beat_cnt", 64'(beat_cnt), 0);
        check("midrst_flush:err_cnt", 64'(err_cnt), 0);

        bq.delete(); gq.delete();
        for (int i = 0; i < 5; i++) begin bq.push_back(gold()); gq.push_back(0); end
        run("after_rst", 8'd5, 3);

        check("sb_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poc_rd_checker.md
POC_RD_CHECKER -- requirements
Module: poc_rd_checker

Interface
REQ-001 Parameter nCK_PER_CLK, default 4: PHY clocks per controller clock.
REQ-002 Parameter DQ_WIDTH, default 64: DRAM data bus width; read beat width W = 2*nCK_PER_CLK*DQ_WIDTH = 512.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: idle-gap limit between beats while checking.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  controller clock; all logic on posedge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 arm  in  1  single-cycle pulse; starts a check run.
REQ-008 num_beats  in  8  number of read beats expected in the run, 0..128.
REQ-009 phy_rddata_valid  in  1  PHY read beat valid this cycle.
REQ-010 phy_rd_data  in  W  PHY read beat data.
REQ-011 busy  out  1  high in CHECK state.
REQ-012 done  out  1  high in DONE state.
REQ-013 pass  out  1  run result; meaningful only when done=1.
REQ-014 timeout  out  1  sticky; run ended by timeout.
REQ-015 overrun  out  1  sticky; beat arrived while not expected.
REQ-016 beat_cnt  out  8  beats checked in current/last run.
REQ-017 err_cnt  out  8  mismatching beats, saturating at 255.
REQ-018 first_err_valid  out  1  at least one mismatch recorded.
REQ-019 first_err_idx  out  7  beat index (0-based) of first mismatch.
REQ-020 err_lane_mask  out  W/8  sticky OR of per-byte mismatches across all beats.

Function
REQ-021 Expected data SHALL be the fixed beat written by the upstream PoC controller: byte k (bits 8k+7:8k) = 0x3F - k, k = 0..63, identical for every beat.
REQ-022 States SHALL be IDLE, CHECK, DONE; reset state IDLE.
REQ-023 arm in IDLE or DONE SHALL enter CHECK next cycle, latch num_beats, clear beat_cnt, err_cnt, first_err_*, err_lane_mask, timeout, overrun, timeout counter.
REQ-024 arm in CHECK SHALL be ignored.
REQ-025 arm with num_beats=0 SHALL go directly to DONE with pass=1 and all counts zero.
REQ-026 A beat SHALL be accepted in CHECK when phy_rddata_valid=1 and accepted-beat count < latched num_beats.
REQ-027 Pipeline: accepted beat registered in stage 1 (cycle N+1), per-byte compare registered in stage 2 (N+2); beat_cnt, err_cnt, err_lane_mask, first_err_* update at end of cycle N+2.
REQ-028 Beat mismatch = any byte differs; err_cnt increments by 1 per mismatching beat, holds at 255.
REQ-029 first_err_idx/first_err_valid SHALL capture only the first mismatching beat of a run.
REQ-030 phy_rddata_valid while IDLE, DONE, or in CHECK after num_beats beats accepted SHALL set overrun and not be checked; arm and valid in same cycle: arm wins, overrun not set.
REQ-031 CHECK to DONE the cycle after the last beat's stage-2 update (done high at N+3 for last beat at N).
REQ-032 Timeout counter SHALL reset on every accepted beat and increment otherwise in CHECK; reaching TIMEOUT_CYCLES SHALL set timeout and go to DONE, in-flight beats still retire.
REQ-033 pass = (err_cnt==0) and timeout==0 and overrun==0 and beat_cnt==latched num_beats, registered on DONE entry.
REQ-034 DONE SHALL hold all result outputs until next arm or rst.

Reset
REQ-035 rst SHALL, at any time including mid-run, force IDLE, flush pipeline, and zero every output (busy, done, pass, timeout, overrun, beat_cnt, err_cnt, first_err_valid, first_err_idx, err_lane_mask).

Verification
REQ-036 arm, num_beats=128, 128 correct beats back-to-back -> done at last-beat+3, pass=1, beat_cnt=128, err_cnt=0.
REQ-037 arm, num_beats=4, beat 2 has byte 5 = 0xFF -> err_cnt=1, first_err_idx=2, err_lane_mask bit5 only, pass=0.
REQ-038 arm, num_beats=8, 3 beats then silence -> timeout=1 after 4096 idle cycles, beat_cnt=3, pass=0.
REQ-039 arm, num_beats=2, 3 valid beats -> overrun=1, beat_cnt=2, pass=0; valid in IDLE also sets overrun.
REQ-040 rst asserted mid-run after 10 beats -> next cycle all outputs 0, IDLE; new arm runs cleanly; arm with num_beats=0 -> done=1, pass=1 next cycle.
